load_store_unit: RTL

- Sits between the CPU datapath and the word-addressed data memory (64 x 32, async read gated by read enable, sync write).
- Accepts one byte-addressed RV32 load/store request at a time.
- Performs byte/halfword extraction with sign/zero extension for loads.
- Implements sub-word stores as a two-cycle read-modify-write sequence.
- Returns a single-cycle response pulse to the pipeline, which stalls on !req_ready.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-addressed data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned/illegal requests instead of force-aligning them.
module load_store_unit #(
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [MEM_AW+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        req_byte, req_half, req_err;
    logic        q_byte, q_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    // Stores with funct3[2] set are not sub-word; they fall through to a word access.
    assign req_byte = (req_funct3[1:0] == 2'b00) && !(req_we && req_funct3[2]);
    assign req_half = (req_funct3[1:0] == 2'b01) && !(req_we && req_funct3[2]);
    assign q_byte   = (f3_q[1:0] == 2'b00) && !(we_q && f3_q[2]);
    assign q_half   = (f3_q[1:0] == 2'b01) && !(we_q && f3_q[2]);

`ifdef LSU_MISALIGN_CHECK_EN
    logic req_illegal, req_misalign;
    assign req_illegal  = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1])
                        || (req_we && req_funct3[2]);
    assign req_misalign = (req_half && req_addr[0])
                        || (!req_byte && !req_half && (req_addr[1:0] != 2'b00));
    assign req_err      = req_illegal || req_misalign;
`else
    assign req_err = 1'b0;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        if (q_byte) begin
            load_val = f3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        end else if (q_half) begin
            load_val = f3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        end else begin
            load_val = mem_rdata;
        end
    end

    always_comb begin
        merged = merge_q;
        if (q_byte) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && (req_byte || req_half)) begin
                        state_d = S_RMW_RD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_addr = addr_q[MEM_AW+1:2];
                if (we_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_read = 1'b1;
                    rdata_d  = load_val;
                end
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                mem_addr = addr_q[MEM_AW+1:2];
                mem_read = 1'b1;
                merge_d  = mem_rdata;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_addr  = addr_q[MEM_AW+1:2];
                mem_write = 1'b1;
                mem_wdata = merged;
                state_d   = S_RESP;
            end
            S_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
